// File: rtl/alu_ctrl_pkg.sv
// Shared types and codes for the execute-stage ALU issue controller.
// Control codes, branch selects, FSM states and the decoded-op payload.
package alu_ctrl_pkg;

  localparam int unsigned CTRL_W = 4;

  localparam logic [3:0] CTRL_ADD    = 4'b0000;
  localparam logic [3:0] CTRL_SUB    = 4'b0001;
  localparam logic [3:0] CTRL_SLL    = 4'b0010;
  localparam logic [3:0] CTRL_SUBU   = 4'b0011;
  localparam logic [3:0] CTRL_SRL    = 4'b0100;
  localparam logic [3:0] CTRL_XOR    = 4'b0101;
  localparam logic [3:0] CTRL_OR     = 4'b0110;
  localparam logic [3:0] CTRL_AND    = 4'b0111;
  localparam logic [3:0] CTRL_MUL    = 4'b1000;
  localparam logic [3:0] CTRL_MULH   = 4'b1001;
  localparam logic [3:0] CTRL_MULHSU = 4'b1010;
  localparam logic [3:0] CTRL_MULHU  = 4'b1011;
  localparam logic [3:0] CTRL_DIV    = 4'b1100;
  localparam logic [3:0] CTRL_DIVU   = 4'b1101;
  localparam logic [3:0] CTRL_REM    = 4'b1110;
  localparam logic [3:0] CTRL_REMU   = 4'b1111;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LT = 2'b10;
  localparam logic [1:0] BR_GE = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  typedef enum logic [1:0] {OP_SINGLE, OP_MUL, OP_DIV} op_class_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [1:0] br;
    logic       slt;
    logic       sra;
    op_class_e  op_class;
  } dec_t;

  // Down-counter width able to hold the longest latency.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUop/funct3/funct7 decode into control word, branch select,
// slt/sra flags and latency class.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec_c
);

  logic m_ext_c;

  assign m_ext_c = (alu_op == 2'b10) && (funct7 == 7'b0000001);

  always_comb begin
    dec_c.ctrl     = CTRL_ADD;
    dec_c.br       = BR_EQ;
    dec_c.slt      = 1'b0;
    dec_c.op_class = OP_SINGLE;
    dec_c.sra      = alu_op[1] & (funct3 == 3'b101) & funct7[5];
    if (alu_op == 2'b01) begin
      unique case (funct3)
        3'b001:         begin dec_c.ctrl = CTRL_SUB;  dec_c.br = BR_NE; end
        3'b100, 3'b110: begin dec_c.ctrl = CTRL_SUBU; dec_c.br = BR_LT; end
        3'b101, 3'b111: begin dec_c.ctrl = CTRL_SUBU; dec_c.br = BR_GE; end
        default:        dec_c.ctrl = CTRL_SUB;
      endcase
    end else if (m_ext_c) begin
      // M-extension takes priority; funct3 maps directly onto the MD codes.
      dec_c.ctrl     = {1'b1, funct3};
      dec_c.op_class = funct3[2] ? OP_DIV : OP_MUL;
    end else if (alu_op[1]) begin
      unique case (funct3)
        3'b000: dec_c.ctrl = (!alu_op[0] && funct7[5]) ? CTRL_SUB : CTRL_ADD;
        3'b001: dec_c.ctrl = CTRL_SLL;
        3'b010: begin dec_c.ctrl = CTRL_SUB;  dec_c.br = BR_LT; dec_c.slt = 1'b1; end
        3'b011: begin dec_c.ctrl = CTRL_SUBU; dec_c.br = BR_LT; dec_c.slt = 1'b1; end
        3'b100: dec_c.ctrl = CTRL_XOR;
        3'b101: dec_c.ctrl = CTRL_SRL;
        3'b110: dec_c.ctrl = CTRL_OR;
        3'b111: dec_c.ctrl = CTRL_AND;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: latches decoded ops on accept, sequences MUL/DIV
// latency, and holds the result word until downstream consumes it.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CTRL_W  = alu_ctrl_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [1:0]        branch_op,
  output logic              slt_c,
  output logic              shift_arith,
  output logic              md_start,
  output logic              md_busy
);
  import alu_ctrl_pkg::*;

  localparam int unsigned CNT_W = cnt_width(MUL_LAT, DIV_LAT);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             md_start_d;
  logic             load_c;
  dec_t             dec_c;

  alu_ctrl_decode u_decode (
    .alu_op (alu_op),
    .funct3 (funct3),
    .funct7 (funct7),
    .dec_c  (dec_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter, handshake; flush overrides everything last.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;
    load_c     = 1'b0;
    in_ready   = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) in_ready = 1'b0;
    if (in_valid && in_ready) begin
      load_c = 1'b1;
      unique case (dec_c.op_class)
        OP_MUL:  begin state_d = BUSY; cnt_d = MUL_LOAD; md_start_d = 1'b1; end
        OP_DIV:  begin state_d = BUSY; cnt_d = DIV_LOAD; md_start_d = 1'b1; end
        default: begin state_d = HOLD; cnt_d = '0; end
      endcase
    end
    if (flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      md_start_d = 1'b0;
      load_c     = 1'b0;
    end
  end

  // Status outputs are flopped from next state; decoded fields load on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      md_busy     <= 1'b0;
      md_start    <= 1'b0;
      alu_ctrl    <= '0;
      branch_op   <= '0;
      slt_c       <= 1'b0;
      shift_arith <= 1'b0;
    end else begin
      out_valid <= (state_d == HOLD);
      md_busy   <= (state_d == BUSY);
      md_start  <= md_start_d;
      if (load_c) begin
        alu_ctrl    <= CTRL_W'(dec_c.ctrl);
        branch_op   <= dec_c.br;
        slt_c       <= dec_c.slt;
        shift_arith <= dec_c.sra;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: decode vector table, hand-built latency/flush/reset
// sequences, and randomized traffic against a timestamp-based reference model.
module tb_alu_issue_ctrl;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 32;
  localparam logic [31:0] ALU_TBL = {4'h7, 4'h6, 4'h4, 4'h5, 4'h3, 4'h1, 4'h2, 4'h0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] alu_op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       in_ready, out_valid, slt_c, shift_arith, md_start, md_busy;
  logic [3:0] alu_ctrl;
  logic [1:0] branch_op;

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .branch_op(branch_op), .slt_c(slt_c),
    .shift_arith(shift_arith), .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] cls;
    logic [3:0] ctrl;
    logic [1:0] br;
    logic       slt;
    logic       sra;
  } ref_t;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] ctrl;
    logic [1:0] br;
    logic       slt;
    logic       sra;
    logic [1:0] cls;
  } vec_t;

  // Reference model: the op in flight is described by its accept edge and latency.
  bit   m_have = 1'b0;
  int   m_acc  = 0;
  int   m_lat  = 0;
  int   edge_n = 0;
  ref_t m_word = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic ref_t ref_dec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    ref_t        d;
    logic [31:0] tbl;
    tbl   = ALU_TBL;
    d     = '0;
    d.sra = op[1] && (f3 == 3'd5) && f7[5];
    if (op == 2'b01) begin
      d.ctrl = f3[2] ? 4'd3 : 4'd1;
      if (f3 == 3'd1)  d.br = 2'd1;
      else if (f3[2]) d.br = {1'b1, f3[0]};
    end else if (op == 2'b10 && f7 == 7'd1) begin
      d.ctrl = {1'b1, f3};
      d.cls  = f3[2] ? 2'd2 : 2'd1;
    end else if (op[1]) begin
      d.ctrl = tbl[{f3, 2'b00} +: 4];
      if (f3 == 3'd0 && op == 2'b10 && f7[5]) d.ctrl = 4'd1;
      if (f3 == 3'd2 || f3 == 3'd3) begin
        d.slt = 1'b1;
        d.br  = 2'd2;
      end
    end
    return d;
  endfunction

  function automatic bit m_holding();
    return m_have && ((edge_n - 1) >= (m_acc + m_lat));
  endfunction

  function automatic bit m_busy();
    return m_have && ((edge_n - 1) < (m_acc + m_lat));
  endfunction

  task automatic model_reset();
    m_have = 1'b0;
    m_word = '0;
  endtask

  task automatic model_edge(input logic iv, input logic [1:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic ordy, input logic fl);
    bit acc_ok;
    acc_ok = iv && !fl && (!m_have || (m_holding() && ordy));
    if (fl) begin
      m_have = 1'b0;
    end else if (acc_ok) begin
      m_word = ref_dec(op, f3, f7);
      m_have = 1'b1;
      m_acc  = edge_n;
      m_lat  = (m_word.cls == 2'd1) ? int'(MUL_LAT) : (m_word.cls == 2'd2) ? int'(DIV_LAT) : 0;
    end else if (m_holding() && ordy) begin
      m_have = 1'b0;
    end
    edge_n++;
  endtask

  task automatic check_model();
    chk("in_ready",  32'(in_ready),    32'(!flush && (!m_have || (m_holding() && out_ready))));
    chk("out_valid", 32'(out_valid),   32'(m_holding()));
    chk("md_busy",   32'(md_busy),     32'(m_busy()));
    chk("md_start",  32'(md_start),    32'(m_have && m_lat > 0 && (edge_n - 1) == m_acc));
    chk("alu_ctrl",  32'(alu_ctrl),    32'(m_word.ctrl));
    chk("branch_op", 32'(branch_op),   32'(m_word.br));
    chk("slt_c",     32'(slt_c),       32'(m_word.slt));
    chk("shift_ar",  32'(shift_arith), 32'(m_word.sra));
  endtask

  // One cycle: drive at negedge, compare against model, then advance model at posedge.
  task automatic step(input logic iv, input logic [1:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = iv;
    alu_op    = op;
    funct3    = f3;
    funct7    = f7;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_model();
    @(posedge clk);
    model_edge(iv, op, f3, f7, ordy, fl);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 100) begin
      #2;
      if (!out_valid && !md_busy) break;
      step(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
      n++;
    end
    chk("drain_idle", 32'({out_valid, md_busy}), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_md_busy"},   32'(md_busy),   32'd0);
    chk({tag, "_md_start"},  32'(md_start),  32'd0);
    chk({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'd0);
    chk({tag, "_branch_op"}, 32'(branch_op), 32'd0);
    chk({tag, "_slt"},       32'(slt_c),     32'd0);
    chk({tag, "_sra"},       32'(shift_arith), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  vec_t vec [24];

  initial begin
    vec[0]  = '{2'b00, 3'b101, 7'h20, 4'h0, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[1]  = '{2'b01, 3'b000, 7'h00, 4'h1, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[2]  = '{2'b01, 3'b001, 7'h00, 4'h1, 2'd1, 1'b0, 1'b0, 2'd0};
    vec[3]  = '{2'b01, 3'b100, 7'h00, 4'h3, 2'd2, 1'b0, 1'b0, 2'd0};
    vec[4]  = '{2'b01, 3'b101, 7'h00, 4'h3, 2'd3, 1'b0, 1'b0, 2'd0};
    vec[5]  = '{2'b01, 3'b110, 7'h00, 4'h3, 2'd2, 1'b0, 1'b0, 2'd0};
    vec[6]  = '{2'b01, 3'b111, 7'h00, 4'h3, 2'd3, 1'b0, 1'b0, 2'd0};
    vec[7]  = '{2'b01, 3'b010, 7'h00, 4'h1, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[8]  = '{2'b10, 3'b000, 7'h20, 4'h1, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[9]  = '{2'b10, 3'b000, 7'h00, 4'h0, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[10] = '{2'b11, 3'b000, 7'h20, 4'h0, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[11] = '{2'b10, 3'b001, 7'h00, 4'h2, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[12] = '{2'b10, 3'b010, 7'h00, 4'h1, 2'd2, 1'b1, 1'b0, 2'd0};
    vec[13] = '{2'b11, 3'b011, 7'h00, 4'h3, 2'd2, 1'b1, 1'b0, 2'd0};
    vec[14] = '{2'b10, 3'b100, 7'h00, 4'h5, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[15] = '{2'b10, 3'b101, 7'h00, 4'h4, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[16] = '{2'b10, 3'b101, 7'h20, 4'h4, 2'd0, 1'b0, 1'b1, 2'd0};
    vec[17] = '{2'b11, 3'b101, 7'h20, 4'h4, 2'd0, 1'b0, 1'b1, 2'd0};
    vec[18] = '{2'b10, 3'b110, 7'h00, 4'h6, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[19] = '{2'b10, 3'b111, 7'h00, 4'h7, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[20] = '{2'b11, 3'b000, 7'h01, 4'h0, 2'd0, 1'b0, 1'b0, 2'd0};
    vec[21] = '{2'b10, 3'b000, 7'h01, 4'h8, 2'd0, 1'b0, 1'b0, 2'd1};
    vec[22] = '{2'b10, 3'b111, 7'h01, 4'hF, 2'd0, 1'b0, 1'b0, 2'd2};
    vec[23] = '{2'b01, 3'b011, 7'h20, 4'h1, 2'd0, 1'b0, 1'b0, 2'd0};

    // Asynchronous reset, asserted between clock edges.
    #2 rst_n = 1'b0;
    #1 check_reset("rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table.
    for (int i = 0; i < 24; i++) begin
      step(1'b1, vec[i].op, vec[i].f3, vec[i].f7, 1'b1, 1'b0);
      #2;
      chk($sformatf("vec%0d_ctrl", i),  32'(alu_ctrl),    32'(vec[i].ctrl));
      chk($sformatf("vec%0d_br", i),    32'(branch_op),   32'(vec[i].br));
      chk($sformatf("vec%0d_slt", i),   32'(slt_c),       32'(vec[i].slt));
      chk($sformatf("vec%0d_sra", i),   32'(shift_arith), 32'(vec[i].sra));
      chk($sformatf("vec%0d_start", i), 32'(md_start),    32'(vec[i].cls != 2'd0));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid),   32'(vec[i].cls == 2'd0));
      if (vec[i].cls != 2'd0) drain();
    end
    drain();

    // DIV latency: start pulse, busy span, valid cycle.
    begin : div_seq
      int starts, busy, vat, irdy;
      starts = 0; busy = 0; vat = 0; irdy = 0;
      step(1'b1, 2'b10, 3'b100, 7'h01, 1'b1, 1'b0);
      for (int c = 1; c <= 40; c++) begin
        #2;
        if (md_start) starts++;
        if (md_busy) begin
          busy++;
          if (in_ready) irdy++;
        end
        if (out_valid) begin
          vat = c;
          break;
        end
        step(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
      end
      chk("div_starts",  32'(starts), 32'd1);
      chk("div_busy",    32'(busy),   32'(DIV_LAT));
      chk("div_valid_at", 32'(vat),   32'(DIV_LAT + 1));
      chk("div_in_ready", 32'(irdy),  32'd0);
      chk("div_ctrl",    32'(alu_ctrl), 32'hC);
      drain();
    end

    // Back-to-back SLT then SLTU.
    step(1'b1, 2'b10, 3'b010, 7'h00, 1'b1, 1'b0);
    #2;
    chk("slt_word", 32'({alu_ctrl, branch_op, slt_c}), 32'({4'h1, 2'd2, 1'b1}));
    step(1'b1, 2'b10, 3'b011, 7'h00, 1'b1, 1'b0);
    #2;
    chk("sltu_word", 32'({alu_ctrl, branch_op, slt_c}), 32'({4'h3, 2'd2, 1'b1}));
    chk("sltu_valid", 32'(out_valid), 32'd1);
    drain();

    // Back-pressure: held op stays stable while a new op waits.
    step(1'b1, 2'b01, 3'b101, 7'h00, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 2'b10, 3'b000, 7'h20, 1'b0, 1'b0);
      #2;
      chk($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_word", c),  32'({alu_ctrl, branch_op}), 32'({4'h3, 2'd3}));
      chk($sformatf("hold%0d_ready", c), 32'(in_ready), 32'd0);
    end
    step(1'b1, 2'b10, 3'b000, 7'h20, 1'b1, 1'b0);
    #2;
    chk("hold_accept_ctrl",  32'(alu_ctrl),  32'h1);
    chk("hold_accept_valid", 32'(out_valid), 32'd1);
    drain();

    // Flush in third MUL busy cycle alongside a new op.
    step(1'b1, 2'b10, 3'b000, 7'h01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
    step(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
    step(1'b1, 2'b10, 3'b111, 7'h00, 1'b1, 1'b1);
    #2;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy",  32'(md_busy),   32'd0);
    chk("flush_start", 32'(md_start),  32'd0);
    chk("flush_ctrl",  32'(alu_ctrl),  32'h8);
    repeat (6) step(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);

    // Reset during DIV busy.
    step(1'b1, 2'b10, 3'b101, 7'h01, 1'b1, 1'b0);
    repeat (3) step(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    #1 check_reset("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) step(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] f7;
      int         r;
      r  = int'($urandom_range(0, 3));
      f7 = (r == 0) ? 7'h01 : (r == 1) ? 7'h20 : 7'($urandom);
      step(1'($urandom_range(0, 1)), 2'($urandom), 3'($urandom), f7,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
